// File: rtl/kb_pkg.sv
// Shared types and PS/2 frame constants for the keyboard reader path.
package kb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    STOP
  } kb_rx_state_t;

  localparam int   PS2_DATA_BITS  = 8;
  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START_LVL  = 1'b0;
  localparam logic PS2_STOP_LVL   = 1'b1;

endpackage

// File: rtl/kb_frame_rx_if.sv
// Pin and result bundle of the PS/2 frame receiver.
interface kb_frame_rx_if;

  logic       kb_clk;
  logic       kb_data;
  logic [8:0] pdata;
  logic       frame_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output kb_clk, kb_data,
    input  pdata, frame_valid, frame_err, busy
  );

  modport slave (
    input  kb_clk, kb_data,
    output pdata, frame_valid, frame_err, busy
  );

endinterface

// File: rtl/kb_sync_filter.sv
// Synchroniser plus level filter for the raw PS/2 clock pin.
module kb_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   clk_s;

  assign clk_s = sync_q[SYNC_STAGES-1];
  assign dout  = filt_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_s != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = clk_s;
      else                              cnt_d  = cnt_q + 1'b1;
    end
  end

  // Idle-high reset so no false edge appears after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

endmodule

// File: rtl/kb_frame_rx.sv
// PS/2 keyboard frame receiver: deserialises start/8 data/parity/stop.
module kb_frame_rx
  import kb_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  kb_frame_rx_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  kb_rx_state_t           state_q, state_d;
  logic [SYNC_STAGES-1:0] dsync_q, dsync_d;
  logic                   clk_f, clk_fd_q;
  logic [8:0]             shreg_q, shreg_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [8:0]             pdata_q, pdata_d;
  logic                   fv_q, fv_d;
  logic                   fe_q, fe_d;
  logic                   busy_q, busy_d;
  logic                   data_s, fall, tmo_hit;

  kb_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.kb_clk),
    .dout    (clk_f)
  );

  assign dsync_d = {dsync_q[SYNC_STAGES-2:0], bus.kb_data};
  assign data_s  = dsync_q[SYNC_STAGES-1];
  assign fall    = clk_fd_q & ~clk_f;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dsync_q   <= '1;
      clk_fd_q  <= 1'b1;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      pdata_q   <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsync_q   <= dsync_d;
      clk_fd_q  <= clk_f;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      pdata_q   <= pdata_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
    end
  end

  // A fall in the timeout cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fall && data_s == PS2_START_LVL) state_d = RECV;
      RECV: begin
        if (fall) begin
          if (bit_cnt_q == 4'(PS2_DATA_BITS)) state_d = STOP;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      STOP: if (fall || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    pdata_d   = pdata_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        tmo_d     = '0;
      end
      RECV, STOP: begin
        if (fall) begin
          tmo_d = '0;
          if (state_q == RECV) begin
            shreg_d   = {data_s, shreg_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (data_s == PS2_STOP_LVL) begin
            pdata_d = shreg_q;
            fv_d    = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else if (tmo_hit) begin
          fe_d  = 1'b1;
          tmo_d = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.pdata       = pdata_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_kb_frame_rx.sv
// Randomised frame-level bench for kb_frame_rx with a byte-level model.
module tb_kb_frame_rx;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 2000;
  localparam int LAT  = SYNC + FILT + 1;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  kb_frame_rx_if kb_if ();

  kb_frame_rx #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (kb_if.slave)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_viol = 0;
  int valid_cyc = 0;
  int err_cyc = 0;
  int fall_cyc = 0;
  logic busy_seen = 1'b0;
  logic fv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [8:0] exp_pd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (kb_if.frame_valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (kb_if.frame_err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (kb_if.frame_valid && kb_if.frame_err) n_viol++;
    if (kb_if.frame_valid && fv_prev) n_viol++;
    if (kb_if.frame_err && fe_prev) n_viol++;
    if (kb_if.busy) busy_seen = 1'b1;
    fv_prev = kb_if.frame_valid;
    fe_prev = kb_if.frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d,
                                           input logic stop);
    return {stop, ~^d, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nb,
                           input int hp);
    for (int i = 0; i < nb; i++) begin
      kb_if.kb_data = bits[i];
      wait_cyc(hp);
      kb_if.kb_clk = 1'b0;
      fall_cyc = cyc;
      wait_cyc(hp);
      kb_if.kb_clk = 1'b1;
    end
    wait_cyc(hp);
    kb_if.kb_data = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d,
                           input logic stop);
    int v0, e0, hp;
    v0 = n_valid;
    e0 = n_err;
    hp = $urandom_range(15, 40);
    send_bits(mk_frame(d, stop), 11, hp);
    wait_cyc(12);
    if (stop) exp_pd = {~^d, d};
    chk({tag, ".valid"}, n_valid - v0, stop ? 1 : 0);
    chk({tag, ".err"}, n_err - e0, stop ? 0 : 1);
    chk({tag, ".pdata"}, kb_if.pdata, exp_pd);
    chk({tag, ".busy"}, kb_if.busy, 0);
    if (stop) chk({tag, ".lat"}, valid_cyc - fall_cyc, LAT);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] rd;
    reset_n = 1'b0;
    kb_if.kb_clk = 1'b1;
    kb_if.kb_data = 1'b1;
    exp_pd = '0;
    wait_cyc(5);
    chk("rst.pdata", kb_if.pdata, 0);
    chk("rst.valid", kb_if.frame_valid, 0);
    chk("rst.err", kb_if.frame_err, 0);
    chk("rst.busy", kb_if.busy, 0);
    reset_n = 1'b1;
    busy_seen = 1'b0;
    wait_cyc(1000);
    chk("idle.pulses", n_valid + n_err, 0);
    chk("idle.busy", busy_seen, 0);

    run_frame("f1c", 8'h1C, 1'b1);
    run_frame("ef0", 8'hF0, 1'b0);

    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    kb_if.kb_clk = 1'b0;
    wait_cyc(3);
    kb_if.kb_clk = 1'b1;
    wait_cyc(30);
    send_bits(11'h7FF, 11, 20);
    wait_cyc(20);
    chk("stray.busy", busy_seen, 0);
    chk("stray.pulses", (n_valid - v0) + (n_err - e0), 0);
    chk("stray.pdata", kb_if.pdata, exp_pd);

    v0 = n_valid;
    e0 = n_err;
    send_bits(mk_frame(8'hA5, 1'b1), 5, 25);
    chk("tmo.busy_mid", kb_if.busy, 1);
    wait_cyc(TMO + 40);
    chk("tmo.err", n_err - e0, 1);
    chk("tmo.when", err_cyc - fall_cyc, TMO + LAT);
    chk("tmo.valid", n_valid - v0, 0);
    chk("tmo.busy", kb_if.busy, 0);
    run_frame("f29", 8'h29, 1'b1);

    send_bits(mk_frame(8'h33, 1'b1), 5, 20);
    reset_n = 1'b0;
    wait_cyc(1);
    chk("mrst.pdata", kb_if.pdata, 0);
    chk("mrst.busy", kb_if.busy, 0);
    chk("mrst.valid", kb_if.frame_valid, 0);
    wait_cyc(2);
    reset_n = 1'b1;
    exp_pd = '0;
    wait_cyc(5);
    run_frame("f5a", 8'h5A, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), rd, ($urandom_range(0, 3) != 0));
    end

    chk("pulse.rules", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
